// File: rtl/score_event_scheduler.sv
// rtl/score_event_scheduler.sv - round-robin score event scheduler with per-source pending counters
//
// Queues monster, boss and asteroid event pulses in saturating pending counters,
// grants at most one event per cycle in round-robin order (MONSTER -> BOSS -> ASTEROID),
// and drives a registered stage-weighted add_amount into the score digits.
// Scoring freezes permanently on game_over until resetN.
//
// Optional feature: define SCORE_COMBO_BONUS_EN to double the points of any grant
// that lands while the combo timer (reloaded to COMBO_WINDOW per grant) is nonzero.
//
// Ports:
//   clk                     in  system clock
//   resetN                  in  asynchronous active-low reset
//   monster_died_pulse      in  one-cycle monster-kill event
//   boss_died_pulse         in  one-cycle boss-kill event
//   asteroid_exploded_pulse in  one-cycle asteroid event
//   stage_num[2:0]          in  current stage, multiplies the source weight
//   game_over               in  level; high freezes scoring
//   add_amount[ADD_WIDTH-1:0] out points to add this cycle (0 = none)
//   add_valid               out add_amount carries a granted event
//   busy                    out any pending counter nonzero (combinational)
//   overflow                out sticky: an event was dropped at saturation

module score_event_scheduler #(
    parameter int MONSTER_WEIGHT  = 1,
    parameter int BOSS_WEIGHT     = 5,
    parameter int ASTEROID_WEIGHT = 2,
    parameter int PEND_WIDTH      = 3,
    parameter int ADD_WIDTH       = 6,
    parameter int COMBO_WINDOW    = 64
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 monster_died_pulse,
    input  logic                 boss_died_pulse,
    input  logic                 asteroid_exploded_pulse,
    input  logic [2:0]           stage_num,
    input  logic                 game_over,
    output logic [ADD_WIDTH-1:0] add_amount,
    output logic                 add_valid,
    output logic                 busy,
    output logic                 overflow
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_FROZEN = 1'b1;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};

    // Source index 0 = MONSTER, 1 = BOSS, 2 = ASTEROID
    logic [2:0][PEND_WIDTH-1:0] pend_q;
    logic [2:0][PEND_WIDTH-1:0] pend_d;
    logic [2:0]                 pulses;
    logic [1:0]                 rr_q;       // source where the next search starts
    logic [0:0]                 state_q;
    logic                       grant_any;
    logic [1:0]                 grant_idx;
    logic                       ovf_set;
    logic [ADD_WIDTH-1:0]       weight_sel;
    logic [ADD_WIDTH-1:0]       grant_amount;

    assign pulses = {asteroid_exploded_pulse, boss_died_pulse, monster_died_pulse};
    assign busy   = (pend_q[0] != '0) || (pend_q[1] != '0) || (pend_q[2] != '0);

    // Round-robin pick among counters as they stood before this cycle's pulses,
    // so a pulse can never be granted in the same cycle it arrives.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] idx;
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            sum = {1'b0, rr_q} + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!grant_any && (pend_q[idx] != '0)) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Pulse increments, grant decrements; both together cancel. A pulse into a
    // saturated counter that is not being drained is dropped and flagged.
    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic granted;
            granted = grant_any && (grant_idx == 2'(i));
            if (pulses[i] && !granted) begin
                if (pend_q[i] == PEND_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + 1'b1;
                end
            end else if (!pulses[i] && granted) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        case (grant_idx)
            2'd0:    weight_sel = ADD_WIDTH'(MONSTER_WEIGHT);
            2'd1:    weight_sel = ADD_WIDTH'(BOSS_WEIGHT);
            default: weight_sel = ADD_WIDTH'(ASTEROID_WEIGHT);
        endcase
    end

`ifdef SCORE_COMBO_BONUS_EN
    localparam int TIMER_W = $clog2(COMBO_WINDOW + 1);
    localparam logic [ADD_WIDTH+3:0] AMOUNT_MAX = {4'd0, {ADD_WIDTH{1'b1}}};

    logic [TIMER_W-1:0]   combo_timer_q;
    logic [ADD_WIDTH+3:0] full_prod;
    logic [ADD_WIDTH+3:0] doubled;

    // Full-width product so the doubled value saturates instead of wrapping.
    assign full_prod = (ADD_WIDTH+4)'(weight_sel) * (ADD_WIDTH+4)'(stage_num);
    assign doubled   = full_prod << 1;

    always_comb begin
        if (combo_timer_q != '0) begin
            grant_amount = (doubled > AMOUNT_MAX) ? AMOUNT_MAX[ADD_WIDTH-1:0]
                                                  : doubled[ADD_WIDTH-1:0];
        end else begin
            grant_amount = full_prod[ADD_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            combo_timer_q <= '0;
        end else if (state_q == ST_FROZEN || game_over) begin
            combo_timer_q <= '0;
        end else if (grant_any) begin
            combo_timer_q <= TIMER_W'(COMBO_WINDOW);
        end else if (combo_timer_q != '0) begin
            combo_timer_q <= combo_timer_q - 1'b1;
        end
    end
`else
    assign grant_amount = weight_sel * ADD_WIDTH'(stage_num);
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend_q     <= '0;
            rr_q       <= 2'd0;
            state_q    <= ST_RUN;
            add_amount <= '0;
            add_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else if (state_q == ST_RUN && !game_over) begin
            pend_q     <= pend_d;
            overflow   <= overflow | ovf_set;
            add_valid  <= grant_any;
            add_amount <= grant_any ? grant_amount : '0;
            if (grant_any) begin
                rr_q <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            end
        end else begin
            // Entering or staying in FROZEN: drop everything pending, keep overflow.
            state_q    <= ST_FROZEN;
            pend_q     <= '0;
            add_valid  <= 1'b0;
            add_amount <= '0;
        end
    end

endmodule

// File: tb/tb_score_event_scheduler.sv
// tb/tb_score_event_scheduler.sv - randomized self-checking bench for score_event_scheduler

module tb_score_event_scheduler;

    localparam int PMAX = 7;
    localparam int AMAX = 63;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       monster_died_pulse = 1'b0;
    logic       boss_died_pulse = 1'b0;
    logic       asteroid_exploded_pulse = 1'b0;
    logic [2:0] stage_num = 3'd1;
    logic       game_over = 1'b0;
    logic [5:0] add_amount;
    logic       add_valid;
    logic       busy;
    logic       overflow;

    score_event_scheduler dut (
        .clk                     (clk),
        .resetN                  (resetN),
        .monster_died_pulse      (monster_died_pulse),
        .boss_died_pulse         (boss_died_pulse),
        .asteroid_exploded_pulse (asteroid_exploded_pulse),
        .stage_num               (stage_num),
        .game_over               (game_over),
        .add_amount              (add_amount),
        .add_valid               (add_valid),
        .busy                    (busy),
        .overflow                (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending event counts per source and who is next in line.
    int m_cnt[3];
    int m_rr;
    int m_timer;
    int m_amt;
    int m_granted[3];
    bit m_frozen, m_ovf, m_valid;
    int weights[3] = '{1, 5, 2};
    int monster_seen;

    task automatic model_reset();
        m_cnt = '{0, 0, 0};
        m_rr = 0; m_timer = 0; m_amt = 0;
        m_frozen = 0; m_ovf = 0; m_valid = 0;
    endtask

    task automatic model_edge();
        int p[3];
        int g;
        int val;
        p[0] = int'(monster_died_pulse);
        p[1] = int'(boss_died_pulse);
        p[2] = int'(asteroid_exploded_pulse);
        if (m_frozen || game_over) begin
            m_frozen = 1;
            m_cnt = '{0, 0, 0};
            m_valid = 0; m_amt = 0; m_timer = 0;
            return;
        end
        g = -1;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (m_rr + k) % 3;
            if (g < 0 && m_cnt[idx] > 0) g = idx;
        end
        for (int i = 0; i < 3; i++) begin
            if (p[i] != 0) begin
                if (m_cnt[i] == PMAX && g != i) m_ovf = 1;
                else m_cnt[i]++;
            end
        end
        if (g >= 0) begin
            m_cnt[g]--;
            m_granted[g]++;
            val = weights[g] * int'(stage_num);
`ifdef SCORE_COMBO_BONUS_EN
            if (m_timer > 0) val = (2 * val > AMAX) ? AMAX : 2 * val;
            m_timer = 64;
`endif
            m_amt = val % (AMAX + 1);
            m_valid = 1;
            m_rr = (g + 1) % 3;
        end else begin
            m_valid = 0; m_amt = 0;
            if (m_timer > 0) m_timer--;
        end
    endtask

    task automatic compare_all();
        check_val("add_valid", int'(add_valid), int'(m_valid));
        check_val("add_amount", int'(add_amount), m_amt);
        check_val("busy", int'(busy), int'(m_cnt[0] + m_cnt[1] + m_cnt[2] > 0));
        check_val("overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (add_valid && add_amount == 6'd1) monster_seen++;
    endtask

    task automatic set_pulses(input bit m, input bit b, input bit a);
        monster_died_pulse = m;
        boss_died_pulse = b;
        asteroid_exploded_pulse = a;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetN = 1'b0;
        set_pulses(0, 0, 0);
        game_over = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        model_reset();
        m_granted = '{0, 0, 0};
        monster_seen = 0;

        do_reset();

        // Isolated monster pulse at stage 3: two-cycle latency.
        stage_num = 3'd3;
        set_pulses(1, 0, 0);
        step();
        check_val("t1_valid_n1", int'(add_valid), 0);
        check_val("t1_busy_n1", int'(busy), 1);
        set_pulses(0, 0, 0);
        step();
        check_val("t1_valid_n2", int'(add_valid), 1);
        check_val("t1_amount_n2", int'(add_amount), 3);
        check_val("t1_busy_after", int'(busy), 0);
        step();
        check_val("t1_valid_n3", int'(add_valid), 0);

        // Three simultaneous events at stage 2 drain in round-robin order.
        do_reset();
        stage_num = 3'd2;
        set_pulses(1, 1, 1);
        step();
        set_pulses(0, 0, 0);
        step();
        check_val("t2_first", int'(add_amount), 2);
        step();
        check_val("t2_second", int'(add_amount), 10);
        step();
        check_val("t2_third", int'(add_amount), 4);
        step();
        check_val("t2_idle", int'(add_valid), 0);

        // Eight monster pulses competing with boss/asteroid streams: none lost.
        do_reset();
        stage_num = 3'd1;
        monster_seen = 0;
        for (int i = 0; i < 8; i++) begin
            set_pulses(1, 1, 1);
            step();
        end
        set_pulses(0, 0, 0);
        repeat (30) step();
        check_val("t3_monster_grants", monster_seen, 8);
        check_val("t3_overflow", int'(overflow), 0);

        // Sustained overload saturates the counters and drops events.
        do_reset();
        stage_num = 3'd1;
        monster_seen = 0;
        m_granted = '{0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            set_pulses(1, 1, 1);
            step();
        end
        set_pulses(0, 0, 0);
        repeat (40) step();
        check_val("t4_overflow", int'(overflow), 1);
        check_val("t4_monster_grants", monster_seen, m_granted[0]);
        check_val("t4_dropped", int'(monster_seen < 16), 1);

        // game_over with pending events freezes everything until reset.
        do_reset();
        stage_num = 3'd4;
        repeat (3) begin
            set_pulses(1, 1, 1);
            step();
        end
        game_over = 1'b1;
        step();
        check_val("t5_valid", int'(add_valid), 0);
        check_val("t5_busy", int'(busy), 0);
        game_over = 1'b0;
        repeat (5) begin
            set_pulses(1, 1, 1);
            step();
            check_val("t5_frozen_valid", int'(add_valid), 0);
            check_val("t5_frozen_busy", int'(busy), 0);
        end
        set_pulses(0, 0, 0);
        do_reset();
        check_val("t5_busy_reset", int'(busy), 0);

`ifdef SCORE_COMBO_BONUS_EN
        // Boss events inside and outside the combo window.
        do_reset();
        stage_num = 3'd1;
        set_pulses(0, 1, 0);
        step();
        set_pulses(0, 0, 0);
        step();
        check_val("t6_first", int'(add_amount), 5);
        repeat (8) step();
        set_pulses(0, 1, 0);
        step();
        set_pulses(0, 0, 0);
        step();
        check_val("t6_combo", int'(add_amount), 10);
        repeat (98) step();
        set_pulses(0, 1, 0);
        step();
        set_pulses(0, 0, 0);
        step();
        check_val("t6_expired", int'(add_amount), 5);
`endif

        // Randomized traffic with stage changes, occasional game_over and resets.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            set_pulses(($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 30),
                       ($urandom_range(0, 99) < 40));
            if ($urandom_range(0, 19) == 0) stage_num = 3'($urandom_range(0, 7));
            game_over = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 499) == 0 || (m_frozen && $urandom_range(0, 29) == 0)) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
